// File: rtl/wave_meter_if.sv
// Sample input and measurement result bundle for wave_meter.
// The timeout signal and its modport entries exist only with WAVE_METER_TIMEOUT_EN.
interface wave_meter_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
);
    logic              din_valid;
    logic [DATA_W-1:0] din;
    logic              clr;
    logic [DATA_W-1:0] vmax;
    logic [DATA_W-1:0] vmin;
    logic [DATA_W-1:0] vpp;
    logic [CNT_W-1:0]  period;
    logic              meas_valid;
    logic              locked;
`ifdef WAVE_METER_TIMEOUT_EN
    logic              timeout;

    modport master (
        output din_valid, din, clr,
        input  vmax, vmin, vpp, period, meas_valid, locked, timeout
    );

    modport slave (
        input  din_valid, din, clr,
        output vmax, vmin, vpp, period, meas_valid, locked, timeout
    );
`else
    modport master (
        output din_valid, din, clr,
        input  vmax, vmin, vpp, period, meas_valid, locked
    );

    modport slave (
        input  din_valid, din, clr,
        output vmax, vmin, vpp, period, meas_valid, locked
    );
`endif
endinterface

// File: rtl/wave_meter.sv
// Per-period max/min/peak-to-peak/period measurement of a sampled waveform using
// hysteretic rising mid-level crossings. Optional feature macro: WAVE_METER_TIMEOUT_EN.
module wave_meter #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16,
    parameter int HYST   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    wave_meter_if.slave bus
);

    localparam logic [DATA_W-1:0] MID     = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W:0]   FULL    = {1'b0, {DATA_W{1'b1}}};
    localparam logic [DATA_W:0]   HYST_W  = (DATA_W+1)'(HYST);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
`ifdef WAVE_METER_TIMEOUT_EN
    localparam logic [CNT_W-1:0]  CNT_PRE = CNT_MAX - CNT_ONE;
`endif

    typedef enum logic {
        SEEK,
        MEASURE
    } state_t;

    state_t            r_state;
    state_t            w_nextState;

    logic [DATA_W-1:0] r_thr;
    logic              r_armed;
    logic [DATA_W-1:0] r_runMax;
    logic [DATA_W-1:0] r_runMin;
    logic [CNT_W-1:0]  r_runCnt;

    logic [DATA_W-1:0] r_vmax;
    logic [DATA_W-1:0] r_vmin;
    logic [DATA_W-1:0] r_vpp;
    logic [CNT_W-1:0]  r_period;
    logic              r_measValid;
    logic              r_locked;
`ifdef WAVE_METER_TIMEOUT_EN
    logic              r_timeout;
    logic              w_timeoutHit;
`endif

    logic [DATA_W:0]   w_thrExt;
    logic [DATA_W:0]   w_dinExt;
    logic [DATA_W:0]   w_lo;
    logic [DATA_W:0]   w_hi;
    logic              w_arm;
    logic              w_cross;
    logic [DATA_W-1:0] w_mean;
    logic              w_startRun;
    logic              w_report;
    logic              w_accum;

    // Thresholds are clamped to the sample range; comparisons run one bit wider
    // so thr +/- HYST never wraps.
    assign w_thrExt = {1'b0, r_thr};
    assign w_dinExt = {1'b0, bus.din};
    assign w_lo     = (w_thrExt > HYST_W) ? (w_thrExt - HYST_W) : '0;
    assign w_hi     = ((w_thrExt + HYST_W) > FULL) ? FULL : (w_thrExt + HYST_W);
    assign w_arm    = (w_dinExt <= w_lo);
    assign w_cross  = bus.din_valid && !bus.clr && r_armed && (w_dinExt >= w_hi) && !w_arm;
    assign w_mean   = DATA_W'(({1'b0, r_runMax} + {1'b0, r_runMin}) >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SEEK;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_startRun  = 1'b0;
        w_report    = 1'b0;
        w_accum     = 1'b0;
`ifdef WAVE_METER_TIMEOUT_EN
        w_timeoutHit = 1'b0;
`endif
        if (bus.clr) begin
            w_nextState = SEEK;
        end else if (bus.din_valid) begin
            case (r_state)
                SEEK: begin
                    if (w_cross) begin
                        w_startRun  = 1'b1;
                        w_nextState = MEASURE;
                    end
                end
                MEASURE: begin
                    if (w_cross) begin
                        w_report   = 1'b1;
                        w_startRun = 1'b1;
                    end else begin
                        w_accum = 1'b1;
`ifdef WAVE_METER_TIMEOUT_EN
                        if (r_runCnt == CNT_PRE) begin
                            w_timeoutHit = 1'b1;
                            w_nextState  = SEEK;
                        end
`endif
                    end
                end
                default: begin
                    w_nextState = SEEK;
                end
            endcase
        end
    end

    // The crossing sample both closes the previous window and opens the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_thr       <= MID;
            r_armed     <= 1'b0;
            r_runMax    <= '0;
            r_runMin    <= '0;
            r_runCnt    <= '0;
            r_vmax      <= '0;
            r_vmin      <= '0;
            r_vpp       <= '0;
            r_period    <= '0;
            r_measValid <= 1'b0;
            r_locked    <= 1'b0;
`ifdef WAVE_METER_TIMEOUT_EN
            r_timeout   <= 1'b0;
`endif
        end else begin
            r_measValid <= w_report;
            if (bus.clr) begin
                r_thr    <= MID;
                r_armed  <= 1'b0;
                r_runCnt <= '0;
                r_locked <= 1'b0;
`ifdef WAVE_METER_TIMEOUT_EN
                r_timeout <= 1'b0;
`endif
            end else if (bus.din_valid) begin
                if (w_arm) begin
                    r_armed <= 1'b1;
                end else if (w_cross) begin
                    r_armed <= 1'b0;
                end

                if (w_report) begin
                    r_vmax   <= r_runMax;
                    r_vmin   <= r_runMin;
                    r_vpp    <= r_runMax - r_runMin;
                    r_period <= r_runCnt;
                    r_locked <= 1'b1;
                    r_thr    <= w_mean;
`ifdef WAVE_METER_TIMEOUT_EN
                    r_timeout <= 1'b0;
`endif
                end

                if (w_startRun) begin
                    r_runMax <= bus.din;
                    r_runMin <= bus.din;
                    r_runCnt <= CNT_ONE;
                end else if (w_accum) begin
                    if (bus.din > r_runMax) begin
                        r_runMax <= bus.din;
                    end
                    if (bus.din < r_runMin) begin
                        r_runMin <= bus.din;
                    end
                    if (r_runCnt != CNT_MAX) begin
                        r_runCnt <= r_runCnt + CNT_ONE;
                    end
                end

`ifdef WAVE_METER_TIMEOUT_EN
                if (w_timeoutHit) begin
                    r_timeout <= 1'b1;
                    r_locked  <= 1'b0;
                    r_thr     <= MID;
                end
`endif
            end
        end
    end

    assign bus.vmax       = r_vmax;
    assign bus.vmin       = r_vmin;
    assign bus.vpp        = r_vpp;
    assign bus.period     = r_period;
    assign bus.meas_valid = r_measValid;
    assign bus.locked     = r_locked;
`ifdef WAVE_METER_TIMEOUT_EN
    assign bus.timeout    = r_timeout;
`endif

endmodule

// File: tb/tb_wave_meter.sv
// Scoreboard bench for wave_meter: directed waveforms push hand-computed reports,
// a negedge monitor pops and compares on every meas_valid.
module tb_wave_meter;

    typedef struct packed {
        logic [7:0]  vmax;
        logic [7:0]  vmin;
        logic [7:0]  vpp;
        logic [15:0] period;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   cycleCount;
    int   lastCycle;
    logic haveLast;
    logic prevValid;
    logic spacingCheck;
    exp_t expQ[$];

    wave_meter_if #(.DATA_W(8), .CNT_W(16)) bus ();

    wave_meter #(.DATA_W(8), .CNT_W(16), .HYST(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    always @(posedge clk) begin
        cycleCount <= cycleCount + 1;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic pushExp(input int vmax, input int vmin, input int period);
        exp_t e;
        e.vmax   = 8'(vmax);
        e.vmin   = 8'(vmin);
        e.vpp    = 8'(vmax - vmin);
        e.period = 16'(period);
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic [7:0] sample, input int gap);
        bus.din       = sample;
        bus.din_valid = 1'b1;
        @(posedge clk);
        #1;
        repeat (gap) begin
            bus.din_valid = 1'b0;
            bus.din       = 8'($urandom_range(0, 255));
            @(posedge clk);
            #1;
        end
        bus.din_valid = 1'b0;
    endtask

    task automatic clrPulse(input logic [7:0] sample);
        bus.clr       = 1'b1;
        bus.din_valid = 1'b1;
        bus.din       = sample;
        @(posedge clk);
        #1;
        bus.clr       = 1'b0;
        bus.din_valid = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_vmax"}, int'(bus.vmax), 0);
        checkOutput({tag, "_vmin"}, int'(bus.vmin), 0);
        checkOutput({tag, "_vpp"}, int'(bus.vpp), 0);
        checkOutput({tag, "_period"}, int'(bus.period), 0);
        checkOutput({tag, "_meas_valid"}, int'(bus.meas_valid), 0);
        checkOutput({tag, "_locked"}, int'(bus.locked), 0);
    endtask

    function automatic logic [7:0] squareSample(input int s);
        return ((s % 16) < 8) ? 8'd0 : 8'd255;
    endfunction

    function automatic logic [7:0] triSample(input int k);
        int j;
        j = k % 256;
        return (j < 128) ? 8'(2 * j) : 8'(2 * (255 - j));
    endfunction

    // Monitor: every meas_valid pulse consumes one expected report.
    always @(negedge clk) begin
        if (rst_n && bus.meas_valid) begin
            checkOutput("no_back_to_back", int'(prevValid), 0);
            if (expQ.size() == 0) begin
                checkOutput("unexpected_meas_valid", expQ.size(), 1);
            end else begin
                checkOutput("vmax", int'(bus.vmax), int'(expQ[0].vmax));
                checkOutput("vmin", int'(bus.vmin), int'(expQ[0].vmin));
                checkOutput("vpp", int'(bus.vpp), int'(expQ[0].vpp));
                checkOutput("period", int'(bus.period), int'(expQ[0].period));
                checkOutput("locked_on_report", int'(bus.locked), 1);
                expQ.delete(0);
            end
            if (spacingCheck && haveLast) begin
                checkOutput("report_spacing", cycleCount - lastCycle, 768);
            end
            lastCycle <= cycleCount;
            haveLast  <= spacingCheck;
        end
        prevValid <= bus.meas_valid;
    end

    initial begin
        total         = 0;
        bad           = 0;
        cycleCount    = 0;
        lastCycle     = 0;
        haveLast      = 1'b0;
        prevValid     = 1'b0;
        spacingCheck  = 1'b0;
        rst_n         = 1'b0;
        bus.din_valid = 1'b0;
        bus.din       = 8'd0;
        bus.clr       = 1'b0;

        #12;
        checkAllZero("reset");
        #8;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 0/255 square; clr lands on an armed 255 sample mid third period.
        pushExp(255, 0, 16);
        pushExp(255, 0, 16);
        pushExp(255, 0, 16);
        for (int s = 0; s < 49; s++) applyStimulus(squareSample(s), 0);
        clrPulse(8'd255);
        checkOutput("clr_locked", int'(bus.locked), 0);
        checkOutput("clr_hold_vmax", int'(bus.vmax), 255);
        checkOutput("clr_hold_vmin", int'(bus.vmin), 0);
        checkOutput("clr_hold_vpp", int'(bus.vpp), 255);
        checkOutput("clr_hold_period", int'(bus.period), 16);
        for (int s = 49; s < 80; s++) applyStimulus(squareSample(s), 0);

        // thr is now 127 (lo=123): 124 must not arm, so the 255s do not cross.
        applyStimulus(8'd124, 0);
        applyStimulus(8'd255, 0);
        applyStimulus(8'd124, 0);
        applyStimulus(8'd255, 0);
        checkOutput("locked_before_reset", int'(bus.locked), 1);

        rst_n = 1'b0;
        #2;
        checkAllZero("async_reset");
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // After reset the first crossing only starts a run.
        pushExp(255, 0, 16);
        pushExp(255, 0, 16);
        for (int s = 0; s <= 40; s++) applyStimulus(squareSample(s), 0);

        // 100/140 square with 120/124 dither inside the band on the high half.
        clrPulse(8'd0);
        pushExp(140, 100, 16);
        pushExp(140, 100, 16);
        pushExp(140, 100, 16);
        pushExp(140, 100, 16);
        repeat (8) applyStimulus(8'd100, 0);
        repeat (8) applyStimulus(8'd140, 0);
        repeat (8) applyStimulus(8'd100, 0);
        for (int p = 0; p < 3; p++) begin
            applyStimulus(8'd140, 0);
            applyStimulus(8'd140, 0);
            applyStimulus(8'd120, 0);
            applyStimulus(8'd124, 0);
            applyStimulus(8'd120, 0);
            applyStimulus(8'd124, 0);
            applyStimulus(8'd140, 0);
            applyStimulus(8'd140, 0);
            repeat (8) applyStimulus(8'd100, 0);
        end
        applyStimulus(8'd140, 0);

        // Triangle with din_valid on every third cycle.
        clrPulse(8'd0);
        spacingCheck = 1'b1;
        pushExp(254, 0, 256);
        pushExp(254, 0, 256);
        pushExp(254, 0, 256);
        for (int k = 0; k <= 834; k++) applyStimulus(triSample(k), 2);
        spacingCheck = 1'b0;

        repeat (5) @(posedge clk);
        #1;
        checkOutput("queue_drained", expQ.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
